transmission8_scan: RTL and testbench
=====================================

# transmission8_scan

Scan controller that drives the 8-lane transmission path and reads back what it delivers. On request it loads an 8-bit word onto the path's data inputs. It then steps the 3-bit select (A,B,C) through channels 0..7, samples the selected output lane, and rebuilds the received word. It sits on both sides of the transmission stage: `tx_data`/`sel_*` feed the stage, and `rx_data` consumes its 8-bit output, where unselected lanes idle high.

## Interface
- `DWELL`, default 1: cycles each channel is held before sampling; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  scan request; accepted only in IDLE.
- `load_data`  in  8  word to transmit; captured when start is accepted.
- `tx_data`  out  8  registered word driven to the stage's data input.
- `sel_a`, `sel_b`, `sel_c`  out  1 each  registered channel select; `sel_a` is the MSB, channel = {a,b,c}.
- `rx_data`  in  8  stage output lanes.
- `busy`  out  1  high while scanning.
- `done`  out  1  one-cycle pulse when the scan completes.
- `rx_word`  out  8  reassembled received word; holds until the next accepted start.
- `match`  out  1  `rx_word == tx_data`; valid while `done` is high and held afterwards.
- `err`  out  1  sticky lane-integrity error for the current scan.

## Operation
- The FSM has three states: IDLE, SCAN and DONE.
- **IDLE, start=1**: load `tx_data` <= `load_data`, set channel to 0, clear the dwell counter, `rx_word` and `err`, and go to SCAN.
- **IDLE, start=0**: stay in IDLE.
- **SCAN**:
  - Hold the channel for DWELL cycles.
  - On the last dwell cycle of channel k:
    - `rx_word[k]` <= `rx_data[k]`.
    - If any `rx_data[j]` with j≠k is 0, set `err` <= 1. `err` stays set until the next accepted start.
  - Then advance the channel by 1 and clear the dwell counter.
  - After sampling channel 7, go to DONE. The channel wraps to 0.
- **DONE**: lasts one cycle. `done`=1, `busy`=0, `match` updated. Then go to IDLE.
- `start` is ignored in SCAN and DONE. It has no queueing or retrigger effect.
- `load_data` changes after acceptance have no effect. `tx_data` is stable for the whole scan.
- The dwell counter is ceil(log2(DWELL+1)) bits and the channel counter is 3 bits; both wrap only under FSM control.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - FSM = IDLE, channel = 0, dwell counter = 0.
  - `tx_data`=0x00, `sel_*`=0, `busy`=0, `done`=0, `rx_word`=0x00, `match`=0, `err`=0.
- Accept edge E0 (start=1 in IDLE): `busy`=1 and `sel`=0 from E0.
- The select for channel k is valid from E0 + k·DWELL.
- `rx_data` is sampled combinationally in the same cycle that the select is presented, i.e. at edge E0 + (k+1)·DWELL.
- `done` is high for exactly the cycle after E0 + 8·DWELL.
- `busy` falls at that same edge.
- A new start can be accepted one cycle after `done`.
- Scan latency, start accept to `done`: 8·DWELL + 1 cycles.
- Reset asserted mid-scan: all outputs go to their reset values immediately. No `done` pulse is produced and the partial `rx_word` is discarded.
- start held high continuously: a new scan begins every 8·DWELL + 2 cycles.

## Test plan
- Loopback through the transmission stage, DWELL=1, `load_data`=0xA5, start pulsed → `busy` 8 cycles, `done` at cycle 9, `rx_word`=0xA5, `match`=1, `err`=0, `sel` sequence 0..7.
- DWELL=3, `load_data`=0x3C → each `sel` value held 3 cycles, `done` 25 cycles after accept, `rx_word`=0x3C, `match`=1.
- Forced fault: stage lane 2 of `rx_data` stuck at 0 while channel 5 is selected → `err`=1 held through `done`, `rx_word`=0x3C, `match`=1.
- Corrupted delivery: `rx_data[4]` forced to 0 while channel 4 is selected, `load_data`=0xFF → `rx_word`=0xEF, `match`=0, `err`=0.
- Start pulsed again at scan cycle 3 with `load_data`=0x00 → ignored; `tx_data` stays 0xA5 and the completion timing is unchanged.
- `rst_n` pulled low at scan cycle 4 → all outputs 0 asynchronously, no `done`. After release, start with 0x5A → clean scan, `rx_word`=0x5A.

Source files
------------

// File: rtl/transmission8_scan.sv
// Scan controller for the 8-lane transmission stage: drives a word and a channel select,
// then samples the selected lane on each channel to rebuild the delivered word.
module transmission8_scan #(
    parameter int unsigned DWELL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] load_data_i,
    output logic [7:0] tx_data_o,
    output logic       sel_a_o,
    output logic       sel_b_o,
    output logic       sel_c_o,
    input  logic [7:0] rx_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rx_word_o,
    output logic       match_o,
    output logic       err_o
);

    localparam int unsigned DwellW = $clog2(DWELL + 1);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        ch_q, ch_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        rx_word_q, rx_word_d;
    logic              match_q, match_d;
    logic              err_q, err_d;
    logic [7:0]        ch_onehot;

    assign ch_onehot = 8'd1 << ch_q;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        dwell_d   = dwell_q;
        tx_d      = tx_q;
        rx_word_d = rx_word_q;
        match_d   = match_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    tx_d      = load_data_i;
                    ch_d      = 3'd0;
                    dwell_d   = '0;
                    rx_word_d = 8'h00;
                    err_d     = 1'b0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                if (dwell_q == DwellLast) begin
                    rx_word_d[ch_q] = rx_data_i[ch_q];
                    // Unselected lanes must idle high; any low one is an integrity fault.
                    if ((rx_data_i | ch_onehot) != 8'hFF) begin
                        err_d = 1'b1;
                    end
                    ch_d    = ch_q + 3'd1;
                    dwell_d = '0;
                    if (ch_q == 3'd7) begin
                        match_d = (rx_word_d == tx_q);
                        state_d = StDone;
                    end
                end else begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ch_q      <= 3'd0;
            dwell_q   <= '0;
            tx_q      <= 8'h00;
            rx_word_q <= 8'h00;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            dwell_q   <= dwell_d;
            tx_q      <= tx_d;
            rx_word_q <= rx_word_d;
            match_q   <= match_d;
            err_q     <= err_d;
        end
    end

    assign tx_data_o = tx_q;
    assign sel_a_o   = ch_q[2];
    assign sel_b_o   = ch_q[1];
    assign sel_c_o   = ch_q[0];
    assign busy_o    = (state_q == StScan);
    assign done_o    = (state_q == StDone);
    assign rx_word_o = rx_word_q;
    assign match_o   = match_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_transmission8_scan.sv
// Self-checking bench: two scanners (DWELL=1 and DWELL=3) fed by a behavioural stage model
// with directed and randomized lane faults.
module tb_transmission8_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_s   [2];
    logic [7:0] load_s    [2];
    logic [7:0] rx_s      [2];
    logic [7:0] tx_s      [2];
    logic       sa_s      [2];
    logic       sb_s      [2];
    logic       sc_s      [2];
    logic       busy_s    [2];
    logic       done_s    [2];
    logic [7:0] rx_word_s [2];
    logic       match_s   [2];
    logic       err_s     [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        transmission8_scan #(.DWELL((g == 0) ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start_i    (start_s[g]),
            .load_data_i(load_s[g]),
            .tx_data_o  (tx_s[g]),
            .sel_a_o    (sa_s[g]),
            .sel_b_o    (sb_s[g]),
            .sel_c_o    (sc_s[g]),
            .rx_data_i  (rx_s[g]),
            .busy_o     (busy_s[g]),
            .done_o     (done_s[g]),
            .rx_word_o  (rx_word_s[g]),
            .match_o    (match_s[g]),
            .err_o      (err_s[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input int idx);
        check_eq("rst_tx", tx_s[idx], 0);
        check_eq("rst_sel", {sa_s[idx], sb_s[idx], sc_s[idx]}, 0);
        check_eq("rst_busy", busy_s[idx], 0);
        check_eq("rst_done", done_s[idx], 0);
        check_eq("rst_rx_word", rx_word_s[idx], 0);
        check_eq("rst_match", match_s[idx], 0);
        check_eq("rst_err", err_s[idx], 0);
    endtask

    // Runs one scan from the current negedge. fch<0 means no fault; retrig/rst_at<0 disable.
    task automatic run_scan(input int idx, input logic [7:0] data, input int fch, input int flane,
                            input int retrig, input int rst_at);
        int d;
        logic [7:0] v, onehot, exp_word;
        logic exp_err;
        d = (idx == 0) ? 1 : 3;
        exp_word = 8'h00;
        exp_err = 1'b0;
        start_s[idx] = 1'b1;
        load_s[idx] = data;
        @(negedge clk);
        start_s[idx] = 1'b0;
        load_s[idx] = 8'($urandom);
        for (int t = 0; t < 8 * d; t++) begin
            int k;
            k = t / d;
            if (t == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset(idx);
                @(negedge clk);
                check_eq("rst_hold_done", done_s[idx], 0);
                rst_n = 1'b1;
                rx_s[idx] = 8'hFF;
                @(negedge clk);
                check_eq("post_rst_busy", busy_s[idx], 0);
                check_eq("post_rst_done", done_s[idx], 0);
                return;
            end
            start_s[idx] = (t == retrig);
            if (t == retrig) load_s[idx] = 8'h00;
            check_eq("busy", busy_s[idx], 1);
            check_eq("done_low", done_s[idx], 0);
            check_eq("sel", {sa_s[idx], sb_s[idx], sc_s[idx]}, k);
            check_eq("tx_data", tx_s[idx], data);
            v = 8'hFF;
            v[k] = data[k];
            if (k == fch) v[flane] = 1'b0;
            rx_s[idx] = v;
            if (t % d == d - 1) begin
                onehot = 8'd1 << k;
                exp_word[k] = v[k];
                if ((v | onehot) != 8'hFF) exp_err = 1'b1;
            end
            @(negedge clk);
        end
        start_s[idx] = 1'b0;
        rx_s[idx] = 8'hFF;
        check_eq("done", done_s[idx], 1);
        check_eq("busy_fall", busy_s[idx], 0);
        check_eq("rx_word", rx_word_s[idx], exp_word);
        check_eq("match", match_s[idx], exp_word == data);
        check_eq("err", err_s[idx], exp_err);
        check_eq("sel_wrap", {sa_s[idx], sb_s[idx], sc_s[idx]}, 0);
        @(negedge clk);
        check_eq("done_pulse", done_s[idx], 0);
        check_eq("idle_busy", busy_s[idx], 0);
        check_eq("rx_word_hold", rx_word_s[idx], exp_word);
        check_eq("match_hold", match_s[idx], exp_word == data);
        check_eq("err_hold", err_s[idx], exp_err);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            load_s[i] = 8'h00;
            rx_s[i] = 8'hFF;
        end
        #12;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(0, 8'hA5, -1, 0, -1, -1);
        run_scan(1, 8'h3C, -1, 0, -1, -1);
        run_scan(1, 8'h3C, 5, 2, -1, -1);
        run_scan(1, 8'hFF, 4, 4, -1, -1);
        run_scan(0, 8'hA5, -1, 0, 3, -1);
        run_scan(0, 8'hA5, -1, 0, -1, 4);
        run_scan(0, 8'h5A, -1, 0, -1, -1);

        for (int n = 0; n < 30; n++) begin
            int idx, fch, flane;
            idx = $urandom_range(0, 1);
            fch = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1;
            flane = $urandom_range(0, 7);
            run_scan(idx, 8'($urandom), fch, flane, ($urandom_range(0, 3) == 0) ? 2 : -1, -1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
